// File: rtl/wtile_col_writer.sv
// rtl/wtile_col_writer.sv - writes one M-row column into the row/k W SRAM port, one word per granted slot
// Optional read-back check of each written column: define WTILE_WB_VERIFY_EN.
module wtile_col_writer #(
    parameter int M      = 8,
    parameter int KMAX   = 1024,
    parameter int DATA_W = 32,
    parameter int BYTE_W = DATA_W / 8,
    parameter int ROW_W  = (M > 1) ? $clog2(M) : 1,
    parameter int K_W    = (KMAX > 1) ? $clog2(KMAX) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                col_valid,
    output logic                col_ready,
    input  logic [K_W-1:0]      col_k,
    input  logic [M-1:0]        col_row_mask,
    input  logic [M*DATA_W-1:0] col_data_flat,
    input  logic                sram_gnt,
    output logic                w_en,
    output logic                w_we,
    output logic                w_re,
    output logic [ROW_W-1:0]    w_row,
    output logic [K_W-1:0]      w_k,
    output logic [DATA_W-1:0]   w_wdata,
    output logic [BYTE_W-1:0]   w_wmask,
    input  logic [DATA_W-1:0]   w_rdata,
    input  logic                w_rvalid,
    output logic                col_done,
    output logic                verify_err
);
    localparam logic [K_W:0]     KMAX_L   = (K_W + 1)'(KMAX);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);

`ifdef WTILE_WB_VERIFY_EN
    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VERIFY, S_DRAIN, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;
`endif

    state_t              r_state;
    logic                r_ready;
    logic                r_done;
    logic [ROW_W-1:0]    r_ptr;
    logic [K_W-1:0]      r_k;
    logic [M-1:0]        r_mask;
    logic [M*DATA_W-1:0] r_data;

    logic                w_slot_hit;
    logic                w_wr;
    logic                w_rd;
    logic                w_last;
    logic [DATA_W-1:0]   w_row_data;

    // A slot only becomes an SRAM access when the port is granted, the row is selected
    // and the column exists; out-of-range columns degrade to idle slots.
    assign w_slot_hit = sram_gnt & r_mask[r_ptr] & ({1'b0, r_k} < KMAX_L);
    assign w_wr       = (r_state == S_WRITE) & w_slot_hit;
    assign w_row_data = r_data[r_ptr*DATA_W +: DATA_W];
    assign w_last     = (r_ptr == LAST_ROW);

    assign w_en       = w_wr | w_rd;
    assign w_we       = w_wr;
    assign w_re       = w_rd;
    assign w_row      = w_en ? r_ptr : '0;
    assign w_k        = w_en ? r_k : '0;
    assign w_wdata    = w_wr ? w_row_data : '0;
    assign w_wmask    = {BYTE_W{w_wr}};
    assign col_ready  = r_ready;
    assign col_done   = r_done;

`ifdef WTILE_WB_VERIFY_EN
    logic [ROW_W-1:0] r_tag [4];
    logic [1:0]       r_wp;
    logic [1:0]       r_rp;
    logic [2:0]       r_cnt;
    logic             r_err;
    logic             w_pop;
    logic             w_drain_done;

    assign w_rd         = (r_state == S_VERIFY) & w_slot_hit;
    assign w_pop        = w_rvalid && (r_cnt != 3'd0) && ((r_state == S_VERIFY) || (r_state == S_DRAIN));
    assign w_drain_done = (r_cnt == 3'd0) || ((r_cnt == 3'd1) && w_pop);
    assign verify_err   = r_err;

    always_ff @(posedge clk) begin
        if (w_rd) begin
            r_tag[r_wp] <= r_ptr;
        end
    end

    // Read tags come back in issue order, so a small FIFO pairs each rvalid with its row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_rd) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
                if (w_rdata != r_data[r_tag[r_rp]*DATA_W +: DATA_W]) begin
                    r_err <= 1'b1;
                end
            end
            r_cnt <= r_cnt + {2'b00, w_rd} - {2'b00, w_pop};
        end
    end
`else
    logic w_unused;

    assign w_rd       = 1'b0;
    assign verify_err = 1'b0;
    assign w_unused   = ^{w_rdata, w_rvalid};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_ptr   <= '0;
            r_k     <= '0;
            r_mask  <= '0;
            r_data  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ready <= 1'b1;
                    if (col_valid && r_ready) begin
                        r_ready <= 1'b0;
                        r_k     <= col_k;
                        r_mask  <= col_row_mask;
                        r_data  <= col_data_flat;
                        r_ptr   <= '0;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (sram_gnt) begin
                        if (w_last) begin
                            r_ptr   <= '0;
`ifdef WTILE_WB_VERIFY_EN
                            r_state <= S_VERIFY;
`else
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
`endif
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
`ifdef WTILE_WB_VERIFY_EN
                S_VERIFY: begin
                    if (sram_gnt) begin
                        if (w_last) begin
                            r_ptr   <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_ptr <= r_ptr + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wtile_col_writer.sv
// tb/tb_wtile_col_writer.sv - self-checking bench for wtile_col_writer (default build, non-power-of-two KMAX)
module tb_wtile_col_writer;
    localparam int M      = 8;
    localparam int KMAX   = 1000;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 4;
    localparam int ROW_W  = 3;
    localparam int K_W    = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                col_valid = 1'b0;
    logic                col_ready;
    logic [K_W-1:0]      col_k = '0;
    logic [M-1:0]        col_row_mask = '0;
    logic [M*DATA_W-1:0] col_data_flat = '0;
    logic                sram_gnt = 1'b1;
    logic                w_en, w_we, w_re;
    logic [ROW_W-1:0]    w_row;
    logic [K_W-1:0]      w_k;
    logic [DATA_W-1:0]   w_wdata;
    logic [BYTE_W-1:0]   w_wmask;
    logic [DATA_W-1:0]   w_rdata = '0;
    logic                w_rvalid = 1'b0;
    logic                col_done;
    logic                verify_err;

    always #5 clk = ~clk;

    wtile_col_writer #(.M(M), .KMAX(KMAX), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .col_valid(col_valid), .col_ready(col_ready), .col_k(col_k),
        .col_row_mask(col_row_mask), .col_data_flat(col_data_flat), .sram_gnt(sram_gnt),
        .w_en(w_en), .w_we(w_we), .w_re(w_re), .w_row(w_row), .w_k(w_k), .w_wdata(w_wdata),
        .w_wmask(w_wmask), .w_rdata(w_rdata), .w_rvalid(w_rvalid), .col_done(col_done),
        .verify_err(verify_err)
    );

    int n_chk = 0, n_fail = 0, n = 0;
    int acc_cnt = 0, done_cnt = 0, wr_cnt = 0, acc_n = 0, done_n = 0;
    bit m_busy = 0, m_done = 0, m_ready = 0;
    int m_g = 0;
    logic [K_W-1:0]    m_k;
    logic [M-1:0]      m_mask;
    logic [DATA_W-1:0] m_row [M];
    logic [DATA_W-1:0] mem [M][KMAX];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: actual %0h required %0h", nm, n, act, exp);
        end
    endtask

    // Column model: granted slot g is row g; a write happens only for selected rows of an
    // existing column; done follows the M-th granted slot; ready returns the cycle after done.
    always @(negedge clk) begin
        bit e_en;
        n++;
        if (!rst_n) begin
            chk("rst_col_ready", col_ready, 0);
            chk("rst_strobes", {w_en, w_we, w_re}, 0);
            chk("rst_addr_data", {w_row, w_k, w_wdata, w_wmask}, 0);
            chk("rst_col_done", col_done, 0);
            m_busy = 0; m_done = 0; m_ready = 1; m_g = 0;
        end else begin
            e_en = m_busy && sram_gnt && m_mask[m_g] && (int'(m_k) < KMAX);
            chk("col_ready", col_ready, m_ready);
            chk("col_done", col_done, m_done);
            chk("w_en", w_en, e_en);
            chk("w_we", w_we, e_en);
            chk("w_re", w_re, 0);
            chk("w_row", w_row, e_en ? m_g : 0);
            chk("w_k", w_k, e_en ? m_k : 0);
            chk("w_wdata", w_wdata, e_en ? m_row[m_g] : 0);
            chk("w_wmask", w_wmask, e_en ? 4'hF : 4'h0);
            chk("verify_err", verify_err, 0);
            if (w_en && w_we && int'(w_k) < KMAX) begin
                mem[w_row][w_k] = w_wdata;
                wr_cnt++;
            end
            if (m_done) begin
                m_done = 0; m_ready = 1; done_n = n; done_cnt++;
            end else if (m_busy && sram_gnt) begin
                m_g++;
                if (m_g == M) begin m_busy = 0; m_done = 1; m_g = 0; end
            end
            if (col_ready === 1'b1 && m_ready && col_valid) begin
                m_busy = 1; m_g = 0; m_ready = 0; m_k = col_k; m_mask = col_row_mask;
                for (int r = 0; r < M; r++) m_row[r] = col_data_flat[r*DATA_W +: DATA_W];
                acc_n = n; acc_cnt++;
            end
        end
    end

    task automatic set_col(input int k, input logic [M-1:0] mask, input logic [DATA_W-1:0] base);
        col_k = K_W'(k);
        col_row_mask = mask;
        for (int r = 0; r < M; r++) col_data_flat[r*DATA_W +: DATA_W] = base + DATA_W'(r);
    endtask

    task automatic wait_evt(input bit on_done, input int target);
        for (int i = 0; i < 80; i++) begin
            if ((on_done ? done_cnt : acc_cnt) >= target) return;
            @(posedge clk); #1;
        end
        n_chk++; n_fail++;
        $display("FAIL timeout waiting for %s", on_done ? "col_done" : "accept");
    endtask

    task automatic run_col(input int k, input logic [M-1:0] mask, input logic [DATA_W-1:0] base,
                           input int stall_at, input int stall_len, output int lat, output int wrs);
        int a0 = acc_cnt, d0 = done_cnt, w0 = wr_cnt;
        bit stalled = 0;
        @(posedge clk); #1;
        set_col(k, mask, base);
        col_valid = 1'b1;
        wait_evt(0, a0 + 1);
        col_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!stalled && stall_at >= 0 && m_busy && m_g == stall_at) begin
                sram_gnt = 1'b0;
                repeat (stall_len) @(posedge clk);
                #1; sram_gnt = 1'b1; stalled = 1;
            end
            if (done_cnt != d0) break;
            @(posedge clk); #1;
        end
        wait_evt(1, d0 + 1);
        lat = done_n - acc_n;
        wrs = wr_cnt - w0;
    endtask

    initial begin
        int lat, wrs, d1n, a0, d0;
        foreach (mem[r, k]) mem[r][k] = '0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("ready_after_reset", col_ready, 1);

        run_col(5, 8'hFF, 32'hA000_0000, -1, 0, lat, wrs);
        chk("basic_latency", lat, 9);
        chk("basic_writes", wrs, 8);
        for (int r = 0; r < M; r++) chk("basic_mem", mem[r][5], 32'hA000_0000 + r);

        run_col(7, 8'b1010_0101, 32'hB000_0000, -1, 0, lat, wrs);
        chk("mask_latency", lat, 9);
        chk("mask_writes", wrs, 4);
        chk("mask_row0", mem[0][7], 32'hB000_0000);
        chk("mask_row1", mem[1][7], 0);
        chk("mask_row2", mem[2][7], 32'hB000_0002);
        chk("mask_row3", mem[3][7], 0);
        chk("mask_row4", mem[4][7], 0);
        chk("mask_row5", mem[5][7], 32'hB000_0005);
        chk("mask_row6", mem[6][7], 0);
        chk("mask_row7", mem[7][7], 32'hB000_0007);

        run_col(9, 8'hFF, 32'hC000_0000, 4, 3, lat, wrs);
        chk("stall_latency", lat, 12);
        chk("stall_writes", wrs, 8);
        chk("stall_row4", mem[4][9], 32'hC000_0004);

        run_col(3, 8'h00, 32'h1234_0000, -1, 0, lat, wrs);
        chk("zero_mask_latency", lat, 9);
        chk("zero_mask_writes", wrs, 0);

        run_col(1010, 8'hFF, 32'h5555_0000, -1, 0, lat, wrs);
        chk("k_over_latency", lat, 9);
        chk("k_over_writes", wrs, 0);

        a0 = acc_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        set_col(0, 8'hFF, 32'hD000_0000);
        col_valid = 1'b1;
        wait_evt(0, a0 + 1);
        set_col(1, 8'hFF, 32'hE000_0000);
        wait_evt(1, d0 + 1);
        d1n = done_n;
        wait_evt(0, a0 + 2);
        col_valid = 1'b0;
        chk("b2b_gap", acc_n - d1n, 1);
        wait_evt(1, d0 + 2);
        chk("b2b_k0", mem[7][0], 32'hD000_0007);
        chk("b2b_k1", mem[7][1], 32'hE000_0007);

        a0 = acc_cnt; d0 = done_cnt;
        @(posedge clk); #1;
        set_col(11, 8'hFF, 32'hF000_0000);
        col_valid = 1'b1;
        wait_evt(0, a0 + 1);
        col_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (m_busy && m_g == 3) break;
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_no_done", done_cnt, d0);
        chk("reset_ready", col_ready, 1);
        chk("reset_partial_row2", mem[2][11], 32'hF000_0002);
        chk("reset_aborted_row3", mem[3][11], 0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
